cordic_rotator: RTL
===================

Name: cordic_rotator

Overview:
- Iterative circular CORDIC in rotation mode. Takes one signed angle and returns its cosine and sine.
- Used beside the vectoring cordic in the SVM kernel datapath.
- Regenerates rotated vector components from an angle, for kernel evaluation and for self-check loops against the vectoring unit.
- One rotation micro-step per clock, under a start/ready/valid handshake.

Parameters:
- WIDTH, 24, width of the angle input and of each result, signed two's complement.
- FRAC, WIDTH-3, fractional bits of the angle and the results (Q2.FRAC with sign bit).
- ITERATIONS, 20, number of CORDIC micro-rotations, 1..WIDTH.
- GUARD, 2, extra internal LSB/MSB bits on the x, y and z registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- angle  in  WIDTH  signed angle in radians, Q2.FRAC.
- enable  in  1  start request; sampled only while ready=1.
- ready  out  1  high while idle and able to accept enable.
- result_cos  out  WIDTH  signed cos(angle), Q2.FRAC; held until the next result.
- result_sin  out  WIDTH  signed sin(angle), Q2.FRAC; held until the next result.
- data_valid  out  1  one-cycle pulse, results updated this cycle.

Behaviour:
- Reset, asynchronous while reset=1: state=IDLE, ready=1, data_valid=0, result_cos=0, result_sin=0, iteration counter=0.
- FSM states:
  - IDLE: ready=1. If enable=1 at a rising edge, load the registers and go to ROTATE. Otherwise stay.
  - ROTATE: ready=0. One micro-rotation per edge, index i=0..ITERATIONS-1. At the edge performing i=ITERATIONS-1: register the outputs, set data_valid=1, go to DONE.
  - DONE: ready=0, data_valid=1 for exactly this cycle. Next edge unconditionally returns to IDLE.
- Load values:
  - x = K·2^FRAC, rounded, with K=0.6072529350 (gain precompensation).
  - y = 0.
  - z = clamped angle.
- Clamp: angle > round(π/2·2^FRAC) uses +that code; angle < −that code uses its negation. No error flag.
- Micro-rotation: d = sign of z (z≥0 → +1).
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
  - Shifts are arithmetic.
  - All registers are WIDTH+2·GUARD bits.
- atan table: atan_i = round(atan(2^−i)·2^(FRAC+GUARD)). It is a constant ROM indexed by the counter and computed at elaboration; no runtime multipliers.
- Output: drop the GUARD LSBs with round-half-up, then saturate to the signed WIDTH range.
- Latency: enable accepted at edge E, data_valid high in the cycle after edge E+ITERATIONS. Next enable can be accepted at edge E+ITERATIONS+2, giving a throughput of one result per ITERATIONS+2 cycles.
- Accuracy: |error| ≤ 8 LSB at FRAC for the defaults, over the full clamped range.
- enable while ready=0 (ROTATE or DONE): ignored, no queueing, in-flight computation unaffected.
- enable held high continuously: a new computation starts each time IDLE is re-entered. The angle is sampled at each acceptance edge.
- angle changing during ROTATE: no effect on the result; the angle is sampled only at acceptance.
- Reset mid-ROTATE: immediate abort. Outputs return to 0, data_valid stays 0, no stale pulse after reset release.
- Outputs change only at the DONE transition.

Test Plan:
- Reset 100 ns, then check ready=1, data_valid=0, results 0. Pulse enable with angle=0. data_valid must pulse exactly 20 cycles after the accept edge, with result_cos=2097152±8 and result_sin=0±8.
- angle=1647099 (π/4) → result_cos=1482910±8, result_sin=1482910±8. Then angle=−2196132 (−π/3) → result_cos=1048576±8, result_sin=−1816186±8.
- angle=4194304 (2.0 rad, out of range) → clamped to π/2 (3294199): result_cos=0±8, result_sin=2097152±8. Same check with angle=−4194304 → result_sin=−2097152±8.
- Hold enable=1 for 60 cycles while changing angle every cycle:
  - Accepts happen only when ready=1, every 22 cycles.
  - Each result matches the angle sampled at its accept edge.
  - data_valid is never high for two consecutive cycles.
- Start angle=1647099, assert reset at iteration 10 for 2 cycles, then release. Outputs must be 0, with no data_valid pulse and ready=1 after release. A fresh π/4 run then completes correctly.

Source files
------------

// File: rtl/cordic_rotator.sv
// rtl/cordic_rotator.sv - iterative circular CORDIC, rotation mode: angle -> cos, sin
// One micro-rotation per clock; results are rounded and saturated back to Q2.FRAC.
module cordic_rotator #(
    parameter int WIDTH      = 24,
    parameter int FRAC       = WIDTH - 3,
    parameter int ITERATIONS = 20,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] angle,
    input  logic                    enable,
    output logic                    ready,
    output logic signed [WIDTH-1:0] result_cos,
    output logic signed [WIDTH-1:0] result_sin,
    output logic                    data_valid
);
    localparam int IW = WIDTH + 2 * GUARD;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int X0 = $rtoi(0.6072529350 * (2.0 ** (FRAC + GUARD)) + 0.5);
    localparam int HP = $rtoi(1.5707963267948966 * (2.0 ** FRAC) + 0.5);

    localparam logic signed [IW-1:0]    X_INIT   = IW'(X0);
    localparam logic signed [WIDTH-1:0] HP_POS   = WIDTH'(HP);
    localparam logic signed [WIDTH-1:0] HP_NEG   = -HP_POS;
    localparam logic signed [IW:0]      RND_HALF = (IW + 1)'(2 ** (GUARD - 1));
    localparam logic signed [IW:0]      OUT_MAX  = (IW + 1)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [IW:0]      OUT_MIN  = -OUT_MAX - (IW + 1)'(1);
    localparam logic [CW-1:0]           LAST_IT  = CW'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    // Elaboration-time arctangent ROM at FRAC+GUARD fractional bits
    logic signed [IW-1:0] atan_rom [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam real A = $atan(1.0 / (2.0 ** g)) * (2.0 ** (FRAC + GUARD));
        assign atan_rom[g] = IW'($rtoi(A + 0.5));
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;

    logic signed [WIDTH-1:0] ang_c;
    logic signed [IW-1:0]   x_sh, y_sh, x_n, y_n, z_n;

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
        logic signed [IW:0] ext;
        logic signed [IW:0] r;
        ext = {v[IW-1], v};
        r   = (ext + RND_HALF) >>> GUARD;
        if (r > OUT_MAX)
            return OUT_MAX[WIDTH-1:0];
        else if (r < OUT_MIN)
            return OUT_MIN[WIDTH-1:0];
        else
            return r[WIDTH-1:0];
    endfunction

    always_comb begin
        ang_c = angle;
        if (angle > HP_POS)
            ang_c = HP_POS;
        else if (angle < HP_NEG)
            ang_c = HP_NEG;
    end

    // d = +1 when z >= 0
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!z_q[IW-1]) begin
            x_n = x_q - y_sh;
            y_n = y_q + x_sh;
            z_n = z_q - atan_rom[cnt_q];
        end else begin
            x_n = x_q + y_sh;
            y_n = y_q - x_sh;
            z_n = z_q + atan_rom[cnt_q];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = {{GUARD{ang_c[WIDTH-1]}}, ang_c, {GUARD{1'b0}}};
                    cnt_d   = '0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                if (cnt_q == LAST_IT) begin
                    cos_d   = round_sat(x_n);
                    sin_d   = round_sat(y_n);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign data_valid = (state_q == DONE);
    assign result_cos = cos_q;
    assign result_sin = sin_q;
endmodule
